// File: rtl/sfx_pkg.sv
// Shared types for the SN76477 effect sequencer: step record, FSM states,
// generator field widths and a step-record constructor for the effect table.
package sfx_pkg;

  localparam int SFX_LFO_W   = 10;
  localparam int SFX_NOISE_W = 12;
  localparam int SFX_VCO_W   = 12;
  localparam int SFX_MIX_W   = 3;
  localparam int SFX_DUR_W   = 6;

  typedef struct packed {
    logic [SFX_LFO_W-1:0]   lfo;
    logic [SFX_NOISE_W-1:0] noise;
    logic [SFX_VCO_W-1:0]   vco;
    logic                   vco_sel;
    logic                   noise_sel;
    logic                   lfo_shift;
    logic [SFX_MIX_W-1:0]   mixer;
    logic [SFX_DUR_W-1:0]   dur;
    logic                   last;
  } sfx_step_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } sfx_state_t;

  function automatic sfx_step_t sfx_mk(
    input logic [SFX_LFO_W-1:0]   lfo,
    input logic [SFX_NOISE_W-1:0] noise,
    input logic [SFX_VCO_W-1:0]   vco,
    input logic                   vco_sel,
    input logic                   noise_sel,
    input logic                   lfo_shift,
    input logic [SFX_MIX_W-1:0]   mixer,
    input logic [SFX_DUR_W-1:0]   dur,
    input logic                   last
  );
    sfx_step_t s;
    s.lfo       = lfo;
    s.noise     = noise;
    s.vco       = vco;
    s.vco_sel   = vco_sel;
    s.noise_sel = noise_sel;
    s.lfo_shift = lfo_shift;
    s.mixer     = mixer;
    s.dur       = dur;
    s.last      = last;
    return s;
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Constant effect table: (effect, step) -> generator settings for that step.
// Effect 0 laser, 1 explosion, 2 siren, 3 alarm. A duration of 0 means 2^DUR_W ticks.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int EFF_W  = 2,
  parameter int STEP_W = 2
) (
  input  logic [EFF_W-1:0]  i_effect,
  input  logic [STEP_W-1:0] i_step,
  output sfx_step_t         o_rec
);

  // Table lookup; unused slots are silent and flagged as last.
  always_comb begin
    o_rec = sfx_mk(10'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b1);
    case (int'(i_effect))
      0: case (int'(i_step))
        0: o_rec = sfx_mk(10'h000, 12'h000, 12'h300, 1'b0, 1'b0, 1'b0, 3'd1, 6'd3, 1'b0);
        1: o_rec = sfx_mk(10'h000, 12'h000, 12'h200, 1'b0, 1'b0, 1'b0, 3'd1, 6'd2, 1'b0);
        2: o_rec = sfx_mk(10'h000, 12'h000, 12'h100, 1'b0, 1'b0, 1'b0, 3'd1, 6'd2, 1'b1);
        default: ;
      endcase
      1: case (int'(i_step))
        0: o_rec = sfx_mk(10'h000, 12'h080, 12'h000, 1'b0, 1'b1, 1'b0, 3'd2, 6'd4, 1'b0);
        1: o_rec = sfx_mk(10'h000, 12'h200, 12'h000, 1'b0, 1'b1, 1'b0, 3'd2, 6'd0, 1'b0);
        2: o_rec = sfx_mk(10'h000, 12'h400, 12'h000, 1'b0, 1'b1, 1'b0, 3'd2, 6'd3, 1'b0);
        3: o_rec = sfx_mk(10'h000, 12'h800, 12'h000, 1'b0, 1'b1, 1'b0, 3'd2, 6'd2, 1'b0);
        default: ;
      endcase
      2: case (int'(i_step))
        0: o_rec = sfx_mk(10'h040, 12'h000, 12'h500, 1'b1, 1'b0, 1'b0, 3'd1, 6'd5, 1'b0);
        1: o_rec = sfx_mk(10'h080, 12'h000, 12'h500, 1'b1, 1'b0, 1'b1, 3'd1, 6'd5, 1'b1);
        default: ;
      endcase
      3: case (int'(i_step))
        0: o_rec = sfx_mk(10'h020, 12'h100, 12'h600, 1'b1, 1'b0, 1'b0, 3'd3, 6'd2, 1'b0);
        1: o_rec = sfx_mk(10'h020, 12'h100, 12'h700, 1'b1, 1'b0, 1'b0, 3'd4, 6'd2, 1'b0);
        2: o_rec = sfx_mk(10'h020, 12'h100, 12'h600, 1'b1, 1'b0, 1'b0, 3'd3, 6'd2, 1'b0);
        3: o_rec = sfx_mk(10'h020, 12'h100, 12'h700, 1'b1, 1'b1, 1'b1, 3'd5, 6'd1, 1'b1);
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/sfx_sequencer.sv
// SN76477 sound-effect sequencer: arbitrates effect requests (highest index wins),
// walks the winning effect's steps from sfx_rom and drives the generator inputs.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  MAX_STEPS = 4,
  parameter int  DUR_W     = SFX_DUR_W,
  localparam int EFF_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] req,
  output logic [9:0]         lfo_freq,
  output logic [11:0]        noise_freq,
  output logic [11:0]        vco_freq,
  output logic               vco_select,
  output logic               noise_select,
  output logic               lfo_shift,
  output logic [2:0]         mixer,
  output logic               busy,
  output logic [EFF_W-1:0]   effect_id
);

  sfx_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_pending, w_pend, w_pend_nxt, w_clr;
  logic [EFF_W-1:0]   r_sel, w_hi;
  logic [STEP_W-1:0]  r_step;
  logic [DUR_W:0]     r_dur, w_dur_load;
  logic               w_any, w_last;
  logic               w_start, w_adv, w_done, w_commit, w_dec;
  sfx_step_t          w_rom;

  sfx_rom #(.EFF_W(EFF_W), .STEP_W(STEP_W)) u_rom (
    .i_effect (r_sel),
    .i_step   (r_step),
    .o_rec    (w_rom)
  );

  // A step ends the effect when flagged last or when the table row is exhausted.
  assign w_last     = w_rom.last || (r_step == STEP_W'(MAX_STEPS - 1));
  assign w_dur_load = (w_rom.dur == '0) ? ((DUR_W+1)'(1) << DUR_W) : (DUR_W+1)'(w_rom.dur);
  assign busy       = (r_state != ST_IDLE);

  // Highest-index request, counting pulses arriving this cycle so a request starts next cycle.
  always_comb begin
    w_pend = r_pending | req;
    w_any  = |w_pend;
    w_hi   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pend[i]) w_hi = EFF_W'(i);
    end
  end

  // Next state and step-control strobes; a start (incl. preemption/restart) beats a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    w_commit    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: w_start = w_any;
      ST_LOAD: begin
        if (w_any && (w_hi >= r_sel)) w_start  = 1'b1;
        else                          w_commit = 1'b1;
      end
      ST_PLAY: begin
        if (w_any && (w_hi >= r_sel)) begin
          w_start = 1'b1;
        end else if (tick) begin
          if (r_dur == (DUR_W+1)'(1)) begin
            if (w_last) w_done = 1'b1;
            else        w_adv  = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_done = 1'b1;
    endcase
    if (w_start)                w_state_nxt = ST_LOAD;
    else if (w_commit)          w_state_nxt = ST_PLAY;
    else if (w_adv)             w_state_nxt = ST_LOAD;
    else if (w_done)            w_state_nxt = ST_IDLE;
  end

  // Pending update: the started bit is consumed, but a fresh pulse on an already-queued bit re-queues it.
  always_comb begin
    w_clr      = w_start ? (NUM_REQ'(1) << w_hi) : '0;
    w_pend_nxt = (w_pend & ~w_clr) | (r_pending & req & w_clr);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Pending bits, selected effect, step index and remaining-tick counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_sel     <= '0;
      r_step    <= '0;
      r_dur     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_start) begin
        r_sel  <= w_hi;
        r_step <= '0;
      end else if (w_adv) begin
        r_step <= r_step + STEP_W'(1);
      end
      if (w_commit)   r_dur <= w_dur_load;
      else if (w_dec) r_dur <= r_dur - (DUR_W+1)'(1);
    end
  end

  // Generator outputs change only when a step is committed, or mixer drops at effect end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfo_freq     <= '0;
      noise_freq   <= '0;
      vco_freq     <= '0;
      vco_select   <= 1'b0;
      noise_select <= 1'b0;
      lfo_shift    <= 1'b0;
      mixer        <= '0;
      effect_id    <= '0;
    end else if (w_commit) begin
      lfo_freq     <= w_rom.lfo;
      noise_freq   <= w_rom.noise;
      vco_freq     <= w_rom.vco;
      vco_select   <= w_rom.vco_sel;
      noise_select <= w_rom.noise_sel;
      lfo_shift    <= w_rom.lfo_shift;
      mixer        <= w_rom.mixer;
      effect_id    <= r_sel;
    end else if (w_done) begin
      mixer        <= '0;
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios with hand-computed expectations plus
// randomized requests/ticks, all checked every cycle against a behavioural model.
module tb_sfx_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [3:0]  req;
  logic [9:0]  lfo_freq;
  logic [11:0] noise_freq, vco_freq;
  logic        vco_select, noise_select, lfo_shift, busy;
  logic [2:0]  mixer;
  logic [1:0]  effect_id;

  sfx_sequencer dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req),
    .lfo_freq(lfo_freq), .noise_freq(noise_freq), .vco_freq(vco_freq),
    .vco_select(vco_select), .noise_select(noise_select), .lfo_shift(lfo_shift),
    .mixer(mixer), .busy(busy), .effect_id(effect_id)
  );

  always #5 clk = ~clk;

  // Effect table: lfo, noise, vco, vco_sel, noise_sel, lfo_shift, mixer, dur, last
  localparam int F_LFO = 0, F_NOI = 1, F_VCO = 2, F_VS = 3, F_NS = 4, F_LS = 5,
                 F_MIX = 6, F_DUR = 7, F_LAST = 8;
  int TBL [4][4][9] = '{
    '{ '{0, 0, 'h300, 0, 0, 0, 1, 3, 0}, '{0, 0, 'h200, 0, 0, 0, 1, 2, 0},
       '{0, 0, 'h100, 0, 0, 0, 1, 2, 1}, '{0, 0, 0, 0, 0, 0, 0, 0, 1} },
    '{ '{0, 'h080, 0, 0, 1, 0, 2, 4, 0}, '{0, 'h200, 0, 0, 1, 0, 2, 0, 0},
       '{0, 'h400, 0, 0, 1, 0, 2, 3, 0}, '{0, 'h800, 0, 0, 1, 0, 2, 2, 0} },
    '{ '{'h040, 0, 'h500, 1, 0, 0, 1, 5, 0}, '{'h080, 0, 'h500, 1, 0, 1, 1, 5, 1},
       '{0, 0, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0, 1} },
    '{ '{'h020, 'h100, 'h600, 1, 0, 0, 3, 2, 0}, '{'h020, 'h100, 'h700, 1, 0, 0, 4, 2, 0},
       '{'h020, 'h100, 'h600, 1, 0, 0, 3, 2, 0}, '{'h020, 'h100, 'h700, 1, 1, 1, 5, 1, 1} }
  };

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  // Model: phase 0 silent, 1 fetching a step, 2 sounding a step
  int m_phase, m_eff, m_step, m_left;
  logic [3:0] m_pend;
  int e_lfo, e_noise, e_vco, e_vs, e_ns, e_ls, e_mix, e_busy, e_eff;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_eff = 0; m_step = 0; m_left = 0; m_pend = '0;
    e_lfo = 0; e_noise = 0; e_vco = 0; e_vs = 0; e_ns = 0; e_ls = 0;
    e_mix = 0; e_busy = 0; e_eff = 0;
  endtask

  task automatic model_update(input logic [3:0] rq, input logic tk);
    logic [3:0] p;
    int hi;
    p  = m_pend | rq;
    hi = -1;
    for (int i = 0; i < 4; i++) if (p[i]) hi = i;
    if (hi >= 0 && (m_phase == 0 || hi >= m_eff)) begin
      for (int i = 0; i < 4; i++) m_pend[i] = (i == hi) ? (m_pend[i] & rq[i]) : p[i];
      m_eff = hi; m_step = 0; m_phase = 1;
    end else begin
      m_pend = p;
      if (m_phase == 1) begin
        e_lfo = TBL[m_eff][m_step][F_LFO]; e_noise = TBL[m_eff][m_step][F_NOI];
        e_vco = TBL[m_eff][m_step][F_VCO]; e_vs = TBL[m_eff][m_step][F_VS];
        e_ns  = TBL[m_eff][m_step][F_NS];  e_ls = TBL[m_eff][m_step][F_LS];
        e_mix = TBL[m_eff][m_step][F_MIX]; e_eff = m_eff;
        m_left  = (TBL[m_eff][m_step][F_DUR] == 0) ? 64 : TBL[m_eff][m_step][F_DUR];
        m_phase = 2;
      end else if (m_phase == 2 && tk) begin
        if (m_left > 1) m_left--;
        else if (TBL[m_eff][m_step][F_LAST] == 1 || m_step == 3) begin
          m_phase = 0; e_mix = 0;
        end else begin
          m_step++; m_phase = 1;
        end
      end
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic compare_all();
    chk("lfo_freq", int'(lfo_freq), e_lfo);
    chk("noise_freq", int'(noise_freq), e_noise);
    chk("vco_freq", int'(vco_freq), e_vco);
    chk("vco_select", int'(vco_select), e_vs);
    chk("noise_select", int'(noise_select), e_ns);
    chk("lfo_shift", int'(lfo_shift), e_ls);
    chk("mixer", int'(mixer), e_mix);
    chk("busy", int'(busy), e_busy);
    chk("effect_id", int'(effect_id), e_eff);
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) if (cmp_en) compare_all();

  task automatic step_cycle(input logic [3:0] rq, input logic tk);
    req = rq; tick = tk;
    model_update(rq, tk);
    @(negedge clk); #1;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_mixer", int'(mixer), 0);
    chk("arst_busy", int'(busy), 0);
    compare_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int nb, bad, k, found;
    logic [3:0] rq;
    reset_n = 1'b0; req = '0; tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_mixer", int'(mixer), 0);
    chk("reset_vco", int'(vco_freq), 0);
    chk("reset_noise", int'(noise_freq), 0);
    chk("reset_lfo", int'(lfo_freq), 0);
    chk("reset_effect_id", int'(effect_id), 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Idle with ticks only
    bad = 0;
    repeat (100) begin
      step_cycle(4'b0000, 1'b1);
      if (busy !== 1'b0 || mixer !== 3'd0) bad++;
    end
    chk("idle_quiet_cycles", bad, 0);

    // Laser: latency and total length with tick every cycle
    step_cycle(4'b0001, 1'b1);
    chk("e0_busy_n1", int'(busy), 1);
    chk("e0_mixer_n1", int'(mixer), 0);
    step_cycle(4'b0000, 1'b1);
    chk("e0_vco_n2", int'(vco_freq), 'h300);
    chk("e0_mixer_n2", int'(mixer), 1);
    nb = 2;
    repeat (18) begin
      step_cycle(4'b0000, 1'b1);
      nb += int'(busy);
    end
    chk("e0_busy_len", nb, 10);
    chk("e0_end_mixer", int'(mixer), 0);

    // Laser preempted by siren
    step_cycle(4'b0001, 1'b0);
    repeat (3) step_cycle(4'b0000, 1'b0);
    chk("e0_hold_vco", int'(vco_freq), 'h300);
    step_cycle(4'b0100, 1'b0);
    chk("pre_busy", int'(busy), 1);
    chk("pre_vco_hold", int'(vco_freq), 'h300);
    step_cycle(4'b0000, 1'b0);
    chk("pre_effect_id", int'(effect_id), 2);
    chk("pre_lfo", int'(lfo_freq), 'h040);
    chk("pre_vco", int'(vco_freq), 'h500);

    // Lower-priority explosion waits for siren to finish
    step_cycle(4'b0010, 1'b1);
    found = -1;
    for (k = 0; k < 60; k++) begin
      step_cycle(4'b0000, 1'b1);
      if (effect_id == 2'd1 && mixer == 3'd2) begin
        found = k;
        break;
      end
    end
    chk("queued_start_cycle", found, 11);
    repeat (90) step_cycle(4'b0000, 1'b1);
    chk("e1_done_busy", int'(busy), 0);

    // Explosion alone: 64-tick step and table-end termination
    step_cycle(4'b0010, 1'b1);
    nb = 1;
    repeat (89) begin
      step_cycle(4'b0000, 1'b1);
      nb += int'(busy);
    end
    chk("e1_busy_len", nb, 77);

    // Restart of the playing effect by its own request, twice
    step_cycle(4'b0010, 1'b1);
    repeat (6) step_cycle(4'b0000, 1'b1);
    chk("rs1_noise_s1", int'(noise_freq), 'h200);
    step_cycle(4'b0010, 1'b1);
    chk("rs1_noise_hold", int'(noise_freq), 'h200);
    step_cycle(4'b0000, 1'b1);
    chk("rs1_noise_s0", int'(noise_freq), 'h080);
    repeat (5) step_cycle(4'b0000, 1'b1);
    chk("rs2_noise_s1", int'(noise_freq), 'h200);
    step_cycle(4'b0010, 1'b0);
    step_cycle(4'b0000, 1'b0);
    chk("rs2_noise_s0", int'(noise_freq), 'h080);
    chk("rs2_effect_id", int'(effect_id), 1);

    // Async reset mid-step drops queued request too
    step_cycle(4'b0001, 1'b0);
    async_reset();
    nb = 0;
    repeat (10) begin
      step_cycle(4'b0000, 1'b1);
      nb += int'(busy);
    end
    chk("post_reset_idle", nb, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rq = '0;
      for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 999) == 0) async_reset();
      step_cycle(rq, 1'($urandom_range(0, 1)));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
